// File: rtl/sap_core.sv
// sap_core: SAP-1 style accumulator CPU with internal program RAM and a valid/ready OUT channel.
// Optional feature macro SAP_CORE_FLAGS_EN adds the carry/zero flags and the JC/JZ conditional jumps.

module sap_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_c,
    output logic              flag_z
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, HALTED} state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state, state_d;
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir, a, b;
    logic [DATA_W-1:0] ram_rd, imm, alu_res;
    logic [3:0]        opcode, fetch_op;
    logic [ADDR_W-1:0] operand;
    logic              is_sub, take_jump;

    assign ram_rd   = ram[mar];
    assign opcode   = ir[DATA_W-1 -: 4];
    assign fetch_op = ram_rd[DATA_W-1 -: 4];
    assign operand  = ir[ADDR_W-1:0];
    assign imm      = {4'b0, ir[DATA_W-5:0]};
    assign is_sub   = (opcode == OP_SUB);
    assign halted   = (state == HALTED);

    // Subtraction is A + ~B + 1, so the carry out means "no borrow".
`ifdef SAP_CORE_FLAGS_EN
    logic alu_c;
    assign {alu_c, alu_res} = {1'b0, a} + {1'b0, is_sub ? ~b : b} + {{DATA_W{1'b0}}, is_sub};

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (state == T4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
            flag_c <= alu_c;
            flag_z <= (alu_res == '0);
        end
    end

    assign take_jump = (opcode == OP_JMP) || (opcode == OP_JC && flag_c) || (opcode == OP_JZ && flag_z);
`else
    assign alu_res   = a + (is_sub ? ~b : b) + {{(DATA_W-1){1'b0}}, is_sub};
    assign flag_c    = 1'b0;
    assign flag_z    = 1'b0;
    assign take_jump = (opcode == OP_JMP);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= T0;
        else     state <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state;
        out_valid = 1'b0;
        case (state)
            T0: state_d = T1;
            T1: state_d = T2;
            T2: begin
                if (opcode == OP_HLT) begin
                    state_d = HALTED;
                end else if (opcode == OP_OUT) begin
                    out_valid = 1'b1;
                    if (out_ready) state_d = T3;
                end else begin
                    state_d = T3;
                end
            end
            T3:      state_d = T4;
            T4:      state_d = T0;
            HALTED:  state_d = HALTED;
            default: state_d = T0;
        endcase
    end

    // out_data is captured as an OUT is fetched so it is already valid in the first T2 cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            mar      <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            out_data <= '0;
        end else begin
            case (state)
                T0: mar <= pc;
                T1: begin
                    ir <= ram_rd;
                    pc <= pc + 1'b1;
                    if (fetch_op == OP_OUT) out_data <= a;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                        OP_LDI:                         a   <= imm;
                        OP_JMP, OP_JC, OP_JZ:           if (take_jump) pc <= operand;
                        default: ;
                    endcase
                end
                T3: begin
                    if (opcode == OP_LDA) a <= ram_rd;
                    if (opcode == OP_ADD || opcode == OP_SUB) b <= ram_rd;
                end
                T4: if (opcode == OP_ADD || opcode == OP_SUB) a <= alu_res;
                default: ;
            endcase
        end
    end

    // NOTE: the RAM is intentionally not reset, so a program loaded under rst survives it.
    always_ff @(posedge clk) begin
        if (prog_we && (rst || halted))
            ram[prog_addr] <= prog_data;
        else if (!rst && state == T3 && opcode == OP_STA)
            ram[mar] <= a;
    end

endmodule

// File: doc/sap_core.md
SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data, accumulator and instruction width; legal only if DATA_W >= 4+ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning address width; internal RAM depth 2^ADDR_W words.
REQ-003 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports prog_we  input  1, prog_addr  input  ADDR_W, prog_data  input  DATA_W, the program-load write port.
REQ-006 SHALL have ports out_data  output  DATA_W and out_valid  output  1, the OUT channel; out_ready  input  1 is its sink acceptance.
REQ-007 SHALL have ports halted  output  1, pc  output  ADDR_W, and flag_c, flag_z  output  1 each.

Function
REQ-008 Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [ADDR_W-1:0]; immediate = bits [DATA_W-5:0], zero-extended.
REQ-009 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; all others execute as NOP.
REQ-010 Sequencer states: T0, T1, T2, T3, T4, HALTED; each instruction passes T0->T4 in order, then returns to T0.
REQ-011 T0: MAR <= PC. T1: IR <= RAM[MAR]; PC <= PC+1 modulo 2^ADDR_W.
REQ-012 LDA: T2 MAR <= operand; T3 A <= RAM[MAR].
REQ-013 ADD/SUB: T2 MAR <= operand; T3 B <= RAM[MAR]; T4 A <= A+B or A-B, truncated to DATA_W.
REQ-014 STA: T2 MAR <= operand; T3 RAM[MAR] <= A.
REQ-015 LDI: T2 A <= immediate. JMP: T2 PC <= operand. JC/JZ: T2 PC <= operand only when flag_c/flag_z is 1.
REQ-016 OUT: in T2, out_data <= A and out_valid = 1; sequencer holds in T2 until the cycle in which out_valid and out_ready are both 1, then advances to T3.
REQ-017 out_data SHALL be stable while out_valid is high; out_valid SHALL drop the cycle after the handshake.
REQ-018 HLT: T2 -> HALTED; HALTED is exited only by rst; halted = 1 exactly while in HALTED.
REQ-019 flag_c: carry out of A+B for ADD; for SUB, carry out of A+~B+1 (1 = no borrow). flag_z = 1 when the ALU result is zero. Only ADD/SUB update flags, in T4.
REQ-020 RAM read is combinational on MAR; RAM write is synchronous.
REQ-021 prog_we writes prog_data to RAM[prog_addr] only while rst = 1 or halted = 1; otherwise it is ignored.
REQ-022 An STA write and a prog_we write SHALL never coincide, because prog_we is disabled while the core is running.
REQ-023 pc output SHALL reflect the PC register.

Reset
REQ-024 When rst = 1 at a clock edge: PC, MAR, IR, A, B, out_data, flags = 0; out_valid = 0; halted = 0; state = T0.
REQ-025 RAM SHALL NOT be cleared by rst, so a program loaded during reset survives it.
REQ-026 rst during any state, including an OUT stall, SHALL abort the instruction with no partial RAM write; out_valid is 0 the cycle after.

Configuration
REQ-027 Macro SAP_CORE_FLAGS_EN defined: flag_c, flag_z, JC and JZ SHALL behave per REQ-015 and REQ-019.
REQ-028 Macro SAP_CORE_FLAGS_EN undefined: no flag registers; flag_c and flag_z tied 0; JC and JZ execute as NOP.

Verification (DATA_W=8, ADDR_W=4, SAP_CORE_FLAGS_EN defined unless stated)
REQ-029 Program loaded under rst: 0:1E 1:2F 2:E0 3:F0 14:1C 15:0E, out_ready = 1, rst released -> exactly one out_valid pulse with out_data = 0x2A; halted = 1 after 18 cycles.
REQ-030 Same program with out_ready held 0 for 7 cycles in OUT -> out_valid high 8 cycles, out_data = 0x2A stable, pc = 3 throughout, then completes normally.
REQ-031 Program 0:5F 1:3A 2:89, RAM10 = 0x0F -> A = 0x00, flag_z = 1, flag_c = 1; JZ is taken and pc = 9.
REQ-032 A = 0xFF plus a RAM value of 0x01 -> A = 0x00, flag_c = 1, flag_z = 1; an all-NOP RAM -> pc counts 15 then wraps to 0.
REQ-033 rst pulsed 1 cycle during an OUT stall -> out_valid = 0 and pc = 0 next cycle; RAM is intact and a rerun reproduces 0x2A.
REQ-034 SAP_CORE_FLAGS_EN undefined, program using JC 9 after a carrying ADD -> jump not taken, pc increments, flag_c = 0.
